// File: rtl/jtag_shift_pkg.sv
//============================================================================
// Module      : jtag_shift_pkg
// Description : Shared opcodes, command-word field positions, FSM encoding
//               and pin-value helper for the JTAG shift-command executor.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package jtag_shift_pkg;

    localparam logic [1:0] OP_TMS_SEQ = 2'b00;
    localparam logic [1:0] OP_SHIFT   = 2'b01;
    localparam logic [1:0] OP_RUNTEST = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    localparam int OP_MSB       = 31;
    localparam int OP_LSB       = 30;
    localparam int LAST_TMS_BIT = 29;
    localparam int CNT_MSB      = 28;
    localparam int CNT_LSB      = 24;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD_WAIT  = 3'd1,
        ST_DECODE    = 3'd2,
        ST_DATA_REQ  = 3'd3,
        ST_DATA_WAIT = 3'd4,
        ST_BIT_LO    = 3'd5,
        ST_BIT_HI    = 3'd6,
        ST_RESULT    = 3'd7
    } state_e;

    // Returns {tms, tdi} for one bit of a command.
    function automatic logic [1:0] bit_pins(input logic [1:0] op,
                                            input logic       last_tms,
                                            input logic       is_last,
                                            input logic       dbit);
        logic [1:0] pins;
        pins = 2'b00;
        case (op)
            OP_TMS_SEQ: pins = {dbit, 1'b0};
            OP_SHIFT:   pins = {is_last & last_tms, dbit};
            default:    pins = 2'b00;
        endcase
        return pins;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_tck_phase_gen.sv
//============================================================================
// Module      : jtag_tck_phase_gen
// Description : TCK half-period divider; strobes the end of each low/high phase.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module jtag_tck_phase_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic rclk,
    input  logic rrst_n,
    input  logic run_i,
    input  logic start_i,
    output logic rise_stb_o,
    output logic fall_stb_o,
    output logic phase_done_o
);

    localparam logic [7:0] c_DIV_LAST = 8'(TCK_DIV - 1);

    logic [7:0] div_q, div_d;
    logic       phase_q, phase_d;

    // phase_q = 0 while tck is low, 1 while tck is high
    always_comb begin
        div_d        = div_q;
        phase_d      = phase_q;
        phase_done_o = run_i && !start_i && (div_q == c_DIV_LAST);
        rise_stb_o   = phase_done_o && !phase_q;
        fall_stb_o   = phase_done_o && phase_q;
        if (start_i) begin
            div_d   = 8'd0;
            phase_d = 1'b0;
        end else if (run_i) begin
            if (phase_done_o) begin
                div_d   = 8'd0;
                phase_d = !phase_q;
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            div_q   <= 8'd0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/jtag_shift_cmd_executor.sv
//============================================================================
// Module      : jtag_shift_cmd_executor
// Description : Pops JTAG shift commands from a FIFO, drives TCK/TMS/TDI and
//               returns captured TDO words on a valid/ready stream.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module jtag_shift_cmd_executor
    import jtag_shift_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TCK_DIV = 4
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              fifo_rempty,
    output logic              fifo_r_en,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo,
    output logic [DATA_W-1:0] tdo_data,
    output logic              tdo_valid,
    input  logic              tdo_ready,
    output logic              busy,
    output logic              cmd_err
);

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              last_tms_q, last_tms_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [4:0]        bit_q, bit_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] tdo_data_q, tdo_data_d;
    logic              tck_q, tck_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic              cmd_err_q, cmd_err_d;

    logic              w_run, w_start, w_rise, w_fall, w_done;
    logic [4:0]        w_bit_nxt;

    assign w_run     = (state_q == ST_BIT_LO) || (state_q == ST_BIT_HI);
    assign w_start   = (state_q == ST_DECODE) || (state_q == ST_DATA_WAIT);
    assign w_bit_nxt = bit_q + 5'd1;

    jtag_tck_phase_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_phase (
        .rclk         (rclk),
        .rrst_n       (rrst_n),
        .run_i        (w_run),
        .start_i      (w_start),
        .rise_stb_o   (w_rise),
        .fall_stb_o   (w_fall),
        .phase_done_o (w_done)
    );

    // Read enable is gated by reset so nothing is popped while held in reset.
    assign fifo_r_en = rrst_n && !fifo_rempty &&
                       ((state_q == ST_IDLE) || (state_q == ST_DATA_REQ));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        last_tms_d = last_tms_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        data_d     = data_q;
        tdo_data_d = tdo_data_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        cmd_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_rempty) state_d = ST_CMD_WAIT;
            end
            ST_CMD_WAIT: begin
                op_d       = fifo_rdata[OP_MSB:OP_LSB];
                last_tms_d = fifo_rdata[LAST_TMS_BIT];
                cnt_d      = fifo_rdata[CNT_MSB:CNT_LSB];
                state_d    = ST_DECODE;
            end
            ST_DECODE: begin
                bit_d = 5'd0;
                case (op_q)
                    OP_TMS_SEQ: state_d = ST_DATA_REQ;
                    OP_SHIFT: begin
                        tdo_data_d = '0;
                        state_d    = ST_DATA_REQ;
                    end
                    OP_RUNTEST: begin
                        data_d  = '0;
                        tms_d   = 1'b0;
                        tdi_d   = 1'b0;
                        state_d = ST_BIT_LO;
                    end
                    default: begin
                        cmd_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                endcase
            end
            ST_DATA_REQ: begin
                if (!fifo_rempty) state_d = ST_DATA_WAIT;
            end
            ST_DATA_WAIT: begin
                data_d         = fifo_rdata;
                {tms_d, tdi_d} = bit_pins(op_q, last_tms_q, cnt_q == 5'd0, fifo_rdata[0]);
                state_d        = ST_BIT_LO;
            end
            ST_BIT_LO: begin
                if (w_rise) begin
                    tck_d = 1'b1;
                    if (op_q == OP_SHIFT) tdo_data_d[bit_q] = tdo;
                end
                if (w_done) state_d = ST_BIT_HI;
            end
            ST_BIT_HI: begin
                if (w_fall) tck_d = 1'b0;
                if (w_done) begin
                    if (bit_q == cnt_q) begin
                        tdi_d   = 1'b0;
                        state_d = (op_q == OP_SHIFT) ? ST_RESULT : ST_IDLE;
                    end else begin
                        bit_d          = w_bit_nxt;
                        {tms_d, tdi_d} = bit_pins(op_q, last_tms_q, w_bit_nxt == cnt_q,
                                                  data_q[w_bit_nxt]);
                        state_d        = ST_BIT_LO;
                    end
                end
            end
            ST_RESULT: begin
                if (tdo_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= 2'b00;
            last_tms_q <= 1'b0;
            cnt_q      <= 5'd0;
            bit_q      <= 5'd0;
            data_q     <= '0;
            tdo_data_q <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            last_tms_q <= last_tms_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            tdo_data_q <= tdo_data_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign tdo_data  = tdo_data_q;
    assign tdo_valid = (state_q == ST_RESULT);
    assign busy      = (state_q != ST_IDLE);
    assign cmd_err   = cmd_err_q;

endmodule

`default_nettype wire

// File: tb/tb_jtag_shift_cmd_executor.sv
//============================================================================
// Module      : tb_jtag_shift_cmd_executor
// Description : Directed self-checking bench for jtag_shift_cmd_executor.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_jtag_shift_cmd_executor;

    logic rclk = 1'b0;
    always #5 rclk = ~rclk;

    int errors = 0;
    int checks = 0;

    // Instance 0: TCK_DIV = 4
    logic        rrst_n, fifo_r_en, tck, tms, tdi, tdo, tdo_valid, tdo_ready, busy, cmd_err;
    logic        fifo_rempty = 1'b1;
    logic [31:0] fifo_rdata = 32'd0;
    logic [31:0] tdo_data;
    logic [31:0] fq[$];
    assign tdo = tdi;

    // Instance 1: TCK_DIV = 1
    logic        rrst_n1, fifo_r_en1, tck1, tms1, tdi1, tdo1, tdo_valid1, tdo_ready1, busy1, cmd_err1;
    logic        fifo_rempty1 = 1'b1;
    logic [31:0] fifo_rdata1 = 32'd0;
    logic [31:0] tdo_data1;
    logic [31:0] fq1[$];
    assign tdo1 = tdi1;

    jtag_shift_cmd_executor #(.DATA_W(32), .TCK_DIV(4)) u_dut (
        .rclk(rclk), .rrst_n(rrst_n), .fifo_rempty(fifo_rempty), .fifo_r_en(fifo_r_en),
        .fifo_rdata(fifo_rdata), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
        .tdo_data(tdo_data), .tdo_valid(tdo_valid), .tdo_ready(tdo_ready),
        .busy(busy), .cmd_err(cmd_err)
    );

    jtag_shift_cmd_executor #(.DATA_W(32), .TCK_DIV(1)) u_dut1 (
        .rclk(rclk), .rrst_n(rrst_n1), .fifo_rempty(fifo_rempty1), .fifo_r_en(fifo_r_en1),
        .fifo_rdata(fifo_rdata1), .tck(tck1), .tms(tms1), .tdi(tdi1), .tdo(tdo1),
        .tdo_data(tdo_data1), .tdo_valid(tdo_valid1), .tdo_ready(tdo_ready1),
        .busy(busy1), .cmd_err(cmd_err1)
    );

    // FIFO models: registered empty flag, data one cycle after r_en.
    always @(posedge rclk) begin
        if (fifo_r_en && fq.size() != 0) fifo_rdata <= fq.pop_front();
        fifo_rempty <= (fq.size() == 0);
    end

    always @(posedge rclk) begin
        if (fifo_r_en1 && fq1.size() != 0) fifo_rdata1 <= fq1.pop_front();
        fifo_rempty1 <= (fq1.size() == 0);
    end

    // Pin monitors
    int   cyc = 0, rises = 0, rens = 0, vcyc = 0, errp = 0;
    int   rise_at[$], fall_at[$];
    logic tms_at[$], tdi_at[$];
    logic tck_prev = 1'b0;
    int   rises1 = 0, vcyc1 = 0;
    logic tck1_prev = 1'b0;

    always @(negedge rclk) begin
        cyc <= cyc + 1;
        if (fifo_r_en) rens <= rens + 1;
        if (tdo_valid) vcyc <= vcyc + 1;
        if (cmd_err)   errp <= errp + 1;
        if (tck && !tck_prev) begin
            rises <= rises + 1;
            rise_at.push_back(cyc);
            tms_at.push_back(tms);
            tdi_at.push_back(tdi);
        end
        if (!tck && tck_prev) fall_at.push_back(cyc);
        tck_prev <= tck;
        if (tck1 && !tck1_prev) rises1 <= rises1 + 1;
        if (tdo_valid1) vcyc1 <= vcyc1 + 1;
        tck1_prev <= tck1;
    end

    task automatic tick();
        @(negedge rclk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
    endtask

    task automatic push1(input logic [31:0] w);
        fq1.push_back(w);
    endtask

    task automatic wait_idle(input int budget, output bit to);
        to = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (tdo_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_valid1(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (tdo_valid1) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // Pack monitored pin history, LSB = first recorded bit.
    function automatic logic [31:0] pack_bits(input int start, input int n, input bit use_tms);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < n; k++) begin
            if (start + k < tdi_at.size()) v[k] = use_tms ? tms_at[start + k] : tdi_at[start + k];
            else v[k] = 1'bx;
        end
        return v;
    endfunction

    task automatic test_reset();
        logic [6:0] pins;
        rrst_n = 1'b0; rrst_n1 = 1'b0; tdo_ready = 1'b0; tdo_ready1 = 1'b0;
        repeat (3) tick();
        pins = {tck, tms, tdi, fifo_r_en, tdo_valid, busy, cmd_err};
        checks++;
        if (pins !== 7'b0100000) begin
            errors++;
            $display("FAIL reset_pins actual=%b required=%b", pins, 7'b0100000);
        end
        checks++;
        if (tdo_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_tdo_data actual=%h required=%h", tdo_data, 32'd0);
        end
        rrst_n = 1'b1; rrst_n1 = 1'b1;
        tick();
    endtask

    task automatic test_idle_empty();
        int bad, n0;
        bad = 0;
        n0 = rens;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (fifo_r_en || busy || tck || !tms) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_empty_pins actual=%0d bad cycles required=0", bad);
        end
        checks++;
        if (rens - n0 != 0) begin
            errors++;
            $display("FAIL idle_empty_ren actual=%0d required=0", rens - n0);
        end
    endtask

    task automatic test_runtest();
        int r0, n0, v0, ri, fi, bad;
        bit to;
        r0 = rises; n0 = rens; v0 = vcyc; ri = rise_at.size(); fi = fall_at.size();
        push(32'h8400_0000);
        wait_idle(400, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL runtest_done actual=timeout required=idle");
        end
        checks++;
        if (rises - r0 != 5) begin
            errors++;
            $display("FAIL runtest_pulses actual=%0d required=5", rises - r0);
        end
        checks++;
        if (rens - n0 != 1) begin
            errors++;
            $display("FAIL runtest_pops actual=%0d required=1", rens - n0);
        end
        checks++;
        if (vcyc - v0 != 0) begin
            errors++;
            $display("FAIL runtest_valid actual=%0d required=0", vcyc - v0);
        end
        bad = 0;
        if (rise_at.size() < ri + 5 || fall_at.size() < fi + 5) bad = 99;
        else begin
            for (int k = 0; k < 5; k++) begin
                if (fall_at[fi + k] - rise_at[ri + k] != 4) bad++;
                if (k > 0 && rise_at[ri + k] - rise_at[ri + k - 1] != 8) bad++;
                if (tms_at[ri + k] !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL runtest_timing actual=%0d bad required=0", bad);
        end
    endtask

    task automatic test_shift();
        int n0, ri;
        bit to;
        n0 = rens; ri = tdi_at.size();
        push(32'h6700_0000);
        push(32'h0000_00A5);
        wait_valid(600, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL shift_valid actual=timeout required=valid");
        end
        checks++;
        if (tdo_data !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL shift_tdo_data actual=%h required=%h", tdo_data, 32'h0000_00A5);
        end
        checks++;
        if (pack_bits(ri, 8, 1'b0) !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL shift_tdi_seq actual=%h required=%h", pack_bits(ri, 8, 1'b0), 32'hA5);
        end
        checks++;
        if (pack_bits(ri, 8, 1'b1) !== 32'h0000_0080) begin
            errors++;
            $display("FAIL shift_tms_seq actual=%h required=%h", pack_bits(ri, 8, 1'b1), 32'h80);
        end
        checks++;
        if ({tck, tms, tdi} !== 3'b010 || rens - n0 != 2) begin
            errors++;
            $display("FAIL shift_end_pins actual=%b pops=%0d required=010 pops=2",
                     {tck, tms, tdi}, rens - n0);
        end
        tdo_ready = 1'b1;
        tick();
        tdo_ready = 1'b0;
        checks++;
        if (tdo_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL shift_handshake actual=valid%b busy%b required=valid0 busy0",
                     tdo_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int n0, r1;
        bit to, stable;
        push(32'h6700_0000);
        push(32'h0000_00A5);
        push(32'h8000_0000);
        wait_valid(600, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL bp_valid actual=timeout required=valid");
        end
        n0 = rens;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tdo_data !== 32'h0000_00A5 || tdo_valid !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_hold actual=%h valid=%b required=000000a5 valid=1", tdo_data, tdo_valid);
        end
        checks++;
        if (rens - n0 != 0 || fifo_rempty !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_pop actual=%0d pops empty=%b required=0 pops empty=0",
                     rens - n0, fifo_rempty);
        end
        r1 = rises;
        tdo_ready = 1'b1;
        tick();
        tdo_ready = 1'b0;
        wait_idle(200, to);
        checks++;
        if (to || rises - r1 != 1 || rens - n0 != 1) begin
            errors++;
            $display("FAIL bp_next_cmd actual=to%0d pulses%0d pops%0d required=to0 pulses1 pops1",
                     to, rises - r1, rens - n0);
        end
    endtask

    task automatic test_tms_seq_rsvd();
        int r0, v0, e0, ri, n0;
        bit to;
        r0 = rises; v0 = vcyc; ri = tms_at.size();
        push(32'h0400_0000);
        push(32'h0000_001F);
        wait_idle(600, to);
        checks++;
        if (to || rises - r0 != 5 || vcyc - v0 != 0) begin
            errors++;
            $display("FAIL tmsseq_pulses actual=to%0d pulses%0d valid%0d required=to0 pulses5 valid0",
                     to, rises - r0, vcyc - v0);
        end
        checks++;
        if (pack_bits(ri, 5, 1'b1) !== 32'h1F || pack_bits(ri, 5, 1'b0) !== 32'h0) begin
            errors++;
            $display("FAIL tmsseq_pins actual=tms%h tdi%h required=tms0000001f tdi00000000",
                     pack_bits(ri, 5, 1'b1), pack_bits(ri, 5, 1'b0));
        end
        r0 = rises; e0 = errp; n0 = rens;
        push(32'hC000_0000);
        wait_idle(50, to);
        repeat (3) tick();
        checks++;
        if (to || errp - e0 != 1) begin
            errors++;
            $display("FAIL rsvd_err_pulse actual=to%0d cycles%0d required=to0 cycles1", to, errp - e0);
        end
        checks++;
        if (rises - r0 != 0 || busy !== 1'b0 || rens - n0 != 1) begin
            errors++;
            $display("FAIL rsvd_quiet actual=pulses%0d busy%b pops%0d required=pulses0 busy0 pops1",
                     rises - r0, busy, rens - n0);
        end
    endtask

    task automatic test_reset_abort();
        int r0, v0;
        bit to, hit;
        logic [6:0] pins;
        r0 = rises1; v0 = vcyc1;
        push1(32'h5F00_0000);
        push1(32'hDEAD_BEEF);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rises1 - r0 >= 4) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach_bit3 actual=%0d pulses required=4", rises1 - r0);
        end
        rrst_n1 = 1'b0;
        tick();
        pins = {tck1, tms1, tdi1, fifo_r_en1, tdo_valid1, busy1, cmd_err1};
        checks++;
        if (pins !== 7'b0100000 || tdo_data1 !== 32'd0) begin
            errors++;
            $display("FAIL abort_reset_pins actual=%b data=%h required=0100000 data=00000000",
                     pins, tdo_data1);
        end
        rrst_n1 = 1'b1;
        repeat (5) tick();
        checks++;
        if (vcyc1 - v0 != 0) begin
            errors++;
            $display("FAIL abort_no_result actual=%0d required=0", vcyc1 - v0);
        end
        push1(32'h6700_0000);
        push1(32'h0000_003C);
        wait_valid1(200, to);
        checks++;
        if (to || tdo_data1 !== 32'h0000_003C) begin
            errors++;
            $display("FAIL abort_recover actual=to%0d data=%h required=to0 data=0000003c",
                     to, tdo_data1);
        end
        tdo_ready1 = 1'b1;
        tick();
        tdo_ready1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_empty();
        test_runtest();
        test_shift();
        test_back_to_back();
        test_tms_seq_rsvd();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
